spawn_scheduler: RTL
====================

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 SHALL have parameter NSLOT, default 4, meaning the number of enemy slots scheduled.
REQ-002 SHALL have parameter BASE_IV, default 120, meaning the spawn interval in ticks at level 0.
REQ-003 SHALL have parameter MIN_IV, default 20, meaning the spawn interval floor in ticks.
REQ-004 SHALL have parameter STEP_IV, default 5, meaning the interval reduction in ticks per level.
REQ-005 SHALL have port clk  in  1  system clock; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port clk_en  in  1  game tick, single-cycle pulse.
REQ-008 SHALL have port scene  in  2  game scene; 1 = playing, any other value = not playing.
REQ-009 SHALL have port level  in  5  current difficulty level.
REQ-010 SHALL have port slot_done  in  NSLOT  per-slot pulse: enemy destroyed or avoided.
REQ-011 SHALL have port spawn  out  NSLOT  one-hot, single-cycle spawn command.
REQ-012 SHALL have port spawn_X  out  9  lane X for the current spawn, valid while spawn != 0.
REQ-013 SHALL have port active  out  NSLOT  slot-occupied flags.
REQ-014 SHALL have port spawned  out  1  equals |spawn.
REQ-015 SHALL have port speed  out  8  road scroll speed.

Function
REQ-016 SHALL implement states IDLE, COUNT, HOLD, SPAWN.
REQ-017 SHALL go to IDLE from any state whenever scene != 1: clear active, load the counter with BASE_IV, drive spawn = 0.
REQ-018 SHALL move IDLE -> COUNT on the first cycle with scene == 1.
REQ-019 SHALL, in COUNT, decrement the 8-bit counter only on clk_en; a clk_en at counter == 1 makes the counter 0 and the state HOLD.
REQ-020 SHALL, in HOLD, move to SPAWN on the next clk when any active bit is 0, independent of clk_en, and otherwise stay in HOLD.
REQ-021 SHALL, in SPAWN, assert exactly one spawn bit for one cycle, set that active bit, reload the counter with the interval, and return to COUNT.
REQ-022 SHALL compute the interval as max(MIN_IV, BASE_IV - STEP_IV*level) without underflow, so level 31 gives MIN_IV.
REQ-023 SHALL pick the slot round-robin: search starts at last_slot+1 mod NSLOT; last_slot resets to NSLOT-1.
REQ-024 SHALL clear active[i] on slot_done[i].
REQ-025 SHALL, when slot_done[i] and the HOLD->SPAWN decision fall in the same cycle, use pre-update active values, so a slot freed in that cycle is eligible from the next cycle.
REQ-026 SHALL ignore slot_done on an inactive slot.
REQ-027 SHALL take the lane from an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) that advances on clk_en in every state, using lane = lfsr[1:0].
REQ-028 SHALL, if the lane equals the previous spawn lane, use (lane+1) mod 4; the previous lane resets to 0.
REQ-029 SHALL map lanes to spawn_X as 0->72, 1->112, 2->152, 3->192.
REQ-030 SHALL drive speed = 3 + level[4:2], registered and updated every cycle.
REQ-031 SHALL register spawn, spawn_X and spawned in the same cycle as the SPAWN state, with zero extra latency.

Reset
REQ-032 SHALL, with rst_n low, force state IDLE, counter BASE_IV, active 0, spawn 0, spawn_X 0, spawned 0, speed 3, lfsr 8'hA5, last_slot NSLOT-1 and previous lane 0, asynchronously.
REQ-033 SHALL leave reset synchronously to clk; the first state change occurs on the second rising edge after rst_n rises.

Structure
REQ-034 SHALL take the scene encoding constants, the lane X table and the LFSR seed/taps from shared package game_pkg.
REQ-035 SHALL put the LFSR in sub-module lfsr8 with ports clk, rst_n, en and q[7:0].

Verification
REQ-036 SHALL verify first spawn: reset, scene=1, level=0, clk_en every 4 clk -> spawn=4'b0001 after exactly 120 ticks, spawn_X in {72,112,152,192}, active=0001.
REQ-037 SHALL verify interval saturation: level=31 -> ticks between spawns = 20; level=4 -> ticks between spawns = 100, speed=4.
REQ-038 SHALL verify full slots: no slot_done and 4 spawns -> state HOLD, no spawn; slot_done=4'b0100 -> spawn=4'b0100 two clk later, with no clk_en needed.
REQ-039 SHALL verify simultaneity: in HOLD, pulse slot_done[1] -> no spawn that cycle, spawn[1] on the next cycle, never two spawn bits together.
REQ-040 SHALL verify the scene drop mid-count: scene 1->2 at counter=50 -> active=0 next clk; scene back to 1 -> next spawn after 120 ticks.
REQ-041 SHALL verify lane rule: force an LFSR giving lane 2 twice in a row -> consecutive spawn_X 152 then 192.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: scene encoding, lane X table and LFSR seed/taps.
package game_pkg;

    localparam int unsigned SCENE_W = 2;
    localparam logic [SCENE_W-1:0] SCENE_TITLE   = 2'd0;
    localparam logic [SCENE_W-1:0] SCENE_PLAYING = 2'd1;
    localparam logic [SCENE_W-1:0] SCENE_OVER    = 2'd2;

    localparam int unsigned LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 (1-based) as a mask over q[7:0].
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    localparam int unsigned X_W    = 9;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HOLD,
        ST_SPAWN
    } sched_state_t;

    function automatic logic [X_W-1:0] lane_x(input logic [LANE_W-1:0] lane);
        logic [X_W-1:0] x;
        case (lane)
            2'd0:    x = 9'd72;
            2'd1:    x = 9'd112;
            2'd2:    x = 9'd152;
            default: x = 9'd192;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/spawn_scheduler_lfsr8.sv
// 8-bit Fibonacci LFSR, advancing one step per enable.
module lfsr8
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Enemy spawn scheduler: interval countdown, round-robin slot pick, lane choice.
module spawn_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NSLOT   = 4,
    parameter int unsigned BASE_IV = 120,
    parameter int unsigned MIN_IV  = 20,
    parameter int unsigned STEP_IV = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic [SCENE_W-1:0] scene,
    input  logic [4:0]         level,
    input  logic [NSLOT-1:0]   slot_done,
    output logic [NSLOT-1:0]   spawn,
    output logic [X_W-1:0]     spawn_X,
    output logic [NSLOT-1:0]   active,
    output logic               spawned,
    output logic [7:0]         speed
);

    localparam int unsigned SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RED_W  = 13;

    sched_state_t       state;
    logic               run;
    logic [CNT_W-1:0]   counter;
    logic [SLOT_W-1:0]  last_slot;
    logic [LANE_W-1:0]  prev_lane;
    logic [LFSR_W-1:0]  lfsr_q;
    logic               unused_lfsr;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (clk_en),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[LFSR_W-1:LANE_W];

    // Interval saturates at MIN_IV instead of wrapping for high levels.
    logic [RED_W-1:0] reduction;
    logic [CNT_W-1:0] interval;
    always_comb begin
        reduction = RED_W'(STEP_IV) * RED_W'(level);
        if (reduction >= RED_W'(BASE_IV - MIN_IV)) begin
            interval = CNT_W'(MIN_IV);
        end else begin
            interval = CNT_W'(RED_W'(BASE_IV) - reduction);
        end
    end

    // Round-robin: lowest free slot above last_slot, else lowest free slot overall.
    logic              hi_found, lo_found, pick_found;
    logic [SLOT_W-1:0] hi_slot, lo_slot, pick_slot;
    logic [NSLOT-1:0]  pick_vec;
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_slot  = '0;
        lo_slot  = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!active[i]) begin
                if (i > int'(last_slot)) begin
                    hi_found = 1'b1;
                    hi_slot  = SLOT_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_slot  = SLOT_W'(i);
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_slot  = hi_found ? hi_slot : lo_slot;
        pick_vec   = NSLOT'(1'b1) << pick_slot;
    end

    logic [LANE_W-1:0] lane_raw, lane_pick;
    assign lane_raw  = lfsr_q[LANE_W-1:0];
    assign lane_pick = (lane_raw == prev_lane) ? lane_raw + 2'd1 : lane_raw;

    // Spawn outputs are registered on the edge entering SPAWN so they coincide with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            run       <= 1'b0;
            counter   <= CNT_W'(BASE_IV);
            active    <= '0;
            spawn     <= '0;
            spawn_X   <= '0;
            spawned   <= 1'b0;
            speed     <= 8'd3;
            last_slot <= SLOT_W'(NSLOT - 1);
            prev_lane <= '0;
        end else begin
            run     <= 1'b1;
            speed   <= 8'd3 + 8'(level[4:2]);
            spawn   <= '0;
            spawned <= 1'b0;
            active  <= active & ~slot_done;
            if (scene != SCENE_PLAYING) begin
                state   <= ST_IDLE;
                active  <= '0;
                counter <= CNT_W'(BASE_IV);
            end else if (run) begin
                case (state)
                    ST_IDLE: state <= ST_COUNT;
                    ST_COUNT: begin
                        if (clk_en) begin
                            if (counter <= CNT_W'(1)) begin
                                counter <= '0;
                                state   <= ST_HOLD;
                            end else begin
                                counter <= counter - CNT_W'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (pick_found) begin
                            state     <= ST_SPAWN;
                            spawn     <= pick_vec;
                            spawned   <= 1'b1;
                            spawn_X   <= lane_x(lane_pick);
                            active    <= (active & ~slot_done) | pick_vec;
                            counter   <= interval;
                            last_slot <= pick_slot;
                            prev_lane <= lane_pick;
                        end
                    end
                    ST_SPAWN: state <= ST_COUNT;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
